// File: rtl/extmem_arb_pkg.sv
// Shared types and default widths for the external-memory burst arbiter.
package extmem_arb_pkg;

  localparam int unsigned DEF_N_REQ  = 3;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LEN_W  = 32;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/extmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr, wrapping.
module rr_pick
  import extmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned OWN_W = idx_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] rr_ptr,
  output logic [OWN_W-1:0] winner,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx[OWN_W-1:0]]) begin
        winner = OWN_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/extmem_arbiter.sv
// Round-robin burst arbiter sharing one external-memory port among N_REQ requesters,
// with incrementing burst addresses and a one-cycle read-return pipe.
module extmem_arbiter
  import extmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req         [N_REQ-1:0],
  input  logic              req_we      [N_REQ-1:0],
  input  logic [ADDR_W-1:0] req_addr    [N_REQ-1:0],
  input  logic [LEN_W-1:0]  req_len     [N_REQ-1:0],
  input  logic [DATA_W-1:0] wdata       [N_REQ-1:0],
  output logic              gnt         [N_REQ-1:0],
  output logic              beat        [N_REQ-1:0],
  output logic              rvalid      [N_REQ-1:0],
  output logic [DATA_W-1:0] rdata,
  output logic              done        [N_REQ-1:0],
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned OWN_W = idx_w(N_REQ);

  arb_state_t        state, state_d;
  logic [OWN_W-1:0]  owner, owner_d;
  logic [OWN_W-1:0]  rr_ptr, ptr_d;
  logic [OWN_W-1:0]  rd_owner;
  logic [OWN_W-1:0]  winner;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining, rem_d;
  logic              rd_pending;
  logic              any;
  logic              issue;
  logic              last;
  logic [N_REQ-1:0]  req_vec;

  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) req_vec[i] = req[i];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req    (req_vec),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      rr_ptr     <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      remaining  <= rem_d;
      rd_pending <= issue && !we_q;
      rd_owner   <= owner;
    end
  end

  // A zero-length burst takes the "last" path without issuing a beat.
  always_comb begin
    state_d = state;
    owner_d = owner;
    ptr_d   = rr_ptr;
    we_d    = we_q;
    addr_d  = addr_q;
    rem_d   = remaining;
    issue   = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          owner_d = winner;
          we_d    = req_we[winner];
          addr_d  = req_addr[winner];
          rem_d   = req_len[winner];
          state_d = BURST;
        end
      end
      BURST: begin
        issue = (remaining != '0);
        last  = (remaining <= LEN_W'(1));
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = remaining - LEN_W'(1);
        end
        if (last) begin
          state_d = IDLE;
          ptr_d   = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + OWN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt[i]    = (state == BURST) && (owner == OWN_W'(i));
      beat[i]   = gnt[i] && issue;
      done[i]   = gnt[i] && last;
      rvalid[i] = rd_pending && (rd_owner == OWN_W'(i));
    end
    mem_we      = issue && we_q;
    mem_re      = issue && !we_q;
    mem_wr_addr = mem_we ? addr_q : '0;
    mem_rd_addr = mem_re ? addr_q : '0;
    mem_wr_data = mem_we ? wdata[owner] : '0;
    rdata       = rd_pending ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed cycle-vector bench for extmem_arbiter with a one-cycle-latency memory model.
module tb_extmem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req      [N-1:0];
  logic          req_we   [N-1:0];
  logic [AW-1:0] req_addr [N-1:0];
  logic [LW-1:0] req_len  [N-1:0];
  logic [DW-1:0] wdata    [N-1:0];
  logic          gnt      [N-1:0];
  logic          beat     [N-1:0];
  logic          rvalid   [N-1:0];
  logic          done     [N-1:0];
  logic [DW-1:0] rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  int checks   = 0;
  int failures = 0;

  extmem_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .gnt         (gnt),
    .beat        (beat),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .done        (done),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory returns address-derived data one cycle after the read strobe.
  always @(posedge clk) if (mem_re) mem_rd_data <= mem_rd_addr[15:0] ^ 16'h5A5A;

  typedef struct {
    logic [2:0]  req;
    logic [15:0] wd_in;
    logic [2:0]  gnt, beat, done, rv;
    logic        we, re;
    logic [31:0] wa, ra;
    logic [15:0] wd, rd;
  } vec_t;

  vec_t tbl [0:39];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                              input logic [2:0] d, input logic [2:0] rv, input logic we,
                              input logic re, input logic [31:0] wa, input logic [31:0] ra,
                              input logic [15:0] wdi, input logic [15:0] wd, input logic [15:0] rd);
    vec_t v;
    v.req = r; v.gnt = g; v.beat = b; v.done = d; v.rv = rv; v.we = we; v.re = re;
    v.wa = wa; v.ra = ra; v.wd_in = wdi; v.wd = wd; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t idle(input logic [2:0] r);
    return mk(r, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endfunction

  task automatic cfg(input int i, input logic we, input logic [31:0] a, input logic [31:0] l);
    req_we[i] = we; req_addr[i] = a; req_len[i] = l;
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req[i]   = v.req[i];
      wdata[i] = v.wd_in + 16'(i);
    end
  endtask

  task automatic check(input vec_t v, input string name);
    logic [2:0] g, b, d, r;
    for (int i = 0; i < N; i++) begin
      g[i] = gnt[i]; b[i] = beat[i]; d[i] = done[i]; r[i] = rvalid[i];
    end
    checks++;
    if ({g, b, d, r, mem_we, mem_re, mem_wr_addr, mem_rd_addr, mem_wr_data, rdata} !==
        {v.gnt, v.beat, v.done, v.rv, v.we, v.re, v.wa, v.ra, v.wd, v.rd}) begin
      failures++;
      $display("FAIL %s: got gnt=%b beat=%b done=%b rvalid=%b we=%b re=%b wa=%h ra=%h wd=%h rd=%h; want gnt=%b beat=%b done=%b rvalid=%b we=%b re=%b wa=%h ra=%h wd=%h rd=%h",
               name, g, b, d, r, mem_we, mem_re, mem_wr_addr, mem_rd_addr, mem_wr_data, rdata,
               v.gnt, v.beat, v.done, v.rv, v.we, v.re, v.wa, v.ra, v.wd, v.rd);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v);
    #1;
    check(v, name);
  endtask

  task automatic run_seg(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) apply(tbl[k], $sformatf("vec%0d", k));
  endtask

  initial begin
    // Contention: r0 write 0x10, r1 read 0x40, r2 write 0x80, len 2 each
    tbl[0]  = idle(3'b111);
    tbl[1]  = mk(3'b111, 3'b001, 3'b001, 3'b000, 3'b000, 1, 0, 32'h10, 0, 16'h1100, 16'h1100, 0);
    tbl[2]  = mk(3'b111, 3'b001, 3'b001, 3'b001, 3'b000, 1, 0, 32'h11, 0, 16'h1200, 16'h1200, 0);
    tbl[3]  = idle(3'b110);
    tbl[4]  = mk(3'b110, 3'b010, 3'b010, 3'b000, 3'b000, 0, 1, 0, 32'h40, 0, 0, 0);
    tbl[5]  = mk(3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 0, 1, 0, 32'h41, 0, 0, 16'h5A1A);
    tbl[6]  = mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 16'h5A1B);
    tbl[7]  = mk(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 1, 0, 32'h80, 0, 16'h1300, 16'h1302, 0);
    tbl[8]  = mk(3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1, 0, 32'h81, 0, 16'h1400, 16'h1402, 0);
    tbl[9]  = idle(3'b101);
    tbl[10] = mk(3'b101, 3'b001, 3'b001, 3'b000, 3'b000, 1, 0, 32'h10, 0, 16'h1500, 16'h1500, 0);
    tbl[11] = mk(3'b101, 3'b001, 3'b001, 3'b001, 3'b000, 1, 0, 32'h11, 0, 16'h1600, 16'h1600, 0);
    tbl[12] = idle(3'b100);
    tbl[13] = mk(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 1, 0, 32'h80, 0, 16'h1700, 16'h1702, 0);
    tbl[14] = mk(3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1, 0, 32'h81, 0, 16'h1800, 16'h1802, 0);
    tbl[15] = idle(3'b000);
    // Single write r1 0x100 len 4, then single read r0 0x20 len 3
    tbl[16] = idle(3'b010);
    tbl[17] = mk(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1, 0, 32'h100, 0, 16'h2000, 16'h2001, 0);
    tbl[18] = mk(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1, 0, 32'h101, 0, 16'h2100, 16'h2101, 0);
    tbl[19] = mk(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1, 0, 32'h102, 0, 16'h2200, 16'h2201, 0);
    tbl[20] = mk(3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 1, 0, 32'h103, 0, 16'h2300, 16'h2301, 0);
    tbl[21] = idle(3'b000);
    tbl[22] = idle(3'b001);
    tbl[23] = mk(3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 0, 1, 0, 32'h20, 0, 0, 0);
    tbl[24] = mk(3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 0, 1, 0, 32'h21, 0, 0, 16'h5A7A);
    tbl[25] = mk(3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 0, 1, 0, 32'h22, 0, 0, 16'h5A7B);
    tbl[26] = mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 16'h5A78);
    // Read r1 0x30 len 2 back-to-back with write r2 0x200 len 1
    tbl[27] = idle(3'b110);
    tbl[28] = mk(3'b110, 3'b010, 3'b010, 3'b000, 3'b000, 0, 1, 0, 32'h30, 0, 0, 0);
    tbl[29] = mk(3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 0, 1, 0, 32'h31, 0, 0, 16'h5A6A);
    tbl[30] = mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 16'h5A6B);
    tbl[31] = mk(3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1, 0, 32'h200, 0, 16'h3000, 16'h3002, 0);
    tbl[32] = idle(3'b000);
    // len 0 on r0, then address wrap on r1 write 0xFFFF_FFFE len 3
    tbl[33] = idle(3'b001);
    tbl[34] = mk(3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 0, 0, 0, 0, 16'hEEEE, 0, 0);
    tbl[35] = idle(3'b010);
    tbl[36] = mk(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1, 0, 32'hFFFF_FFFE, 0, 16'h4000, 16'h4001, 0);
    tbl[37] = mk(3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1, 0, 32'hFFFF_FFFF, 0, 16'h4100, 16'h4101, 0);
    tbl[38] = mk(3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 1, 0, 32'h0000_0000, 0, 16'h4200, 16'h4201, 0);
    tbl[39] = idle(3'b000);

    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; wdata[i] = '0;
      cfg(i, 1'b0, '0, '0);
    end

    rst = 1'b0;
    apply(idle(3'b111), "reset_req_high");
    apply(idle(3'b000), "reset_idle");
    rst = 1'b1;

    cfg(0, 1'b1, 32'h10, 2); cfg(1, 1'b0, 32'h40, 2); cfg(2, 1'b1, 32'h80, 2);
    run_seg(0, 15);
    cfg(0, 1'b0, 32'h20, 3); cfg(1, 1'b1, 32'h100, 4);
    run_seg(16, 26);
    cfg(1, 1'b0, 32'h30, 2); cfg(2, 1'b1, 32'h200, 1);
    run_seg(27, 32);
    cfg(0, 1'b0, 32'h0, 0); cfg(1, 1'b1, 32'hFFFF_FFFE, 3);
    run_seg(33, 39);

    // Reset during beat 2 of a 5-beat read by r2; rr_ptr is 2 beforehand
    cfg(2, 1'b0, 32'h300, 5); cfg(1, 1'b0, 32'h500, 2);
    apply(idle(3'b100), "rst_seq_idle");
    apply(mk(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 0, 1, 0, 32'h300, 0, 0, 0), "rst_seq_beat1");
    apply(mk(3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 0, 1, 0, 32'h301, 0, 0, 16'h595A), "rst_seq_beat2");
    rst = 1'b0;
    for (int i = 0; i < N; i++) req[i] = (i != 0);
    #1;
    check(idle(3'b110), "rst_async_clear");
    apply(idle(3'b110), "rst_held");
    drive(idle(3'b110));
    rst = 1'b1;
    #1;
    check(idle(3'b110), "rst_release_idle");
    apply(mk(3'b110, 3'b010, 3'b010, 3'b000, 3'b000, 0, 1, 0, 32'h500, 0, 0, 0), "post_rst_r1_first");
    apply(mk(3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 0, 1, 0, 32'h501, 0, 0, 16'h5F5A), "post_rst_r1_done");
    apply(mk(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 16'h5F5B), "post_rst_last_rvalid");
    apply(idle(3'b000), "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
